// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock behind a
// start/done handshake, with divide-by-zero reported alongside the results.
module restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  // The partial remainder always stays below the divisor, so its top bit is
  // implicitly zero and only the low WIDTH bits are stored.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    // Subtraction through the shared adder: inverted operand plus carry-in of one.
    trial    = shifted + {1'b1, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  // NOTE: non-blocking assignments keep every register update in this block
  // reading the pre-edge values, independent of statement order.
  // NOTE: the datapath registers (rem_q, quo_q, dvs_q) are deliberately left
  // out of reset; they are always loaded on an accepted start before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dvs_q <= divisor;
            if (divisor != '0) begin
              state <= RUN;
              busy  <= 1'b1;
              count <= '0;
              rem_q <= '0;
              quo_q <= dividend;
            end else begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= quo_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
